// File: rtl/encoder_8_to_3_seq_if.sv
// Request/grant bundle for the registered 8-to-3 priority encoder.
// master = request source and code consumer, slave = encoder.
interface encoder_8_to_3_seq_if;
    logic       d0, d1, d2, d3, d4, d5, d6, d7;
    logic       ack;
    logic       x, y, z;
    logic       valid;
    logic [7:0] pending;

    modport master (
        output d0, d1, d2, d3, d4, d5, d6, d7, ack,
        input  x, y, z, valid, pending
    );

    modport slave (
        input  d0, d1, d2, d3, d4, d5, d6, d7, ack,
        output x, y, z, valid, pending
    );
endinterface

// File: rtl/encoder_8_to_3_seq.sv
// Latches request pulses and presents the highest-priority pending index as {x,y,z}.
// Latency: 2 edges from request pulse to valid; at least one idle cycle between grants.
// Backpressure: the code holds with valid=1 until ack; requests keep accumulating meanwhile.
module encoder_8_to_3_seq #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    encoder_8_to_3_seq_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] req_vec;
    logic [7:0] clr;
    logic [2:0] code_q, code_d;
    logic [2:0] sel_idx;
    logic       valid_q, valid_d;

    assign req_vec = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};

    // Selection looks at the registered pending bits, never the raw request lines.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PRIORITY_HIGH) begin
                if (pend_q[i]) sel_idx = 3'(i);
            end else begin
                if (pend_q[7-i]) sel_idx = 3'(7 - i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        clr     = 8'h00;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = GRANT;
                    code_d  = sel_idx;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    clr     = 8'd1 << code_q;
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // A new request on the clearing edge wins, so the line is granted again later.
    assign pend_d = req_vec | (pend_q & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 8'h00;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign bus.x       = code_q[2];
    assign bus.y       = code_q[1];
    assign bus.z       = code_q[0];
    assign bus.valid   = valid_q;
    assign bus.pending = pend_q;

endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// Directed bench for encoder_8_to_3_seq: both priority orders, expected codes via a scoreboard queue.
module tb_encoder_8_to_3_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    encoder_8_to_3_seq_if bus_hi ();
    encoder_8_to_3_seq_if bus_lo ();

    encoder_8_to_3_seq #(.PRIORITY_HIGH(1'b1)) u_hi (.clk(clk), .rst_n(rst_n), .bus(bus_hi));
    encoder_8_to_3_seq #(.PRIORITY_HIGH(1'b0)) u_lo (.clk(clk), .rst_n(rst_n), .bus(bus_lo));

    int         tests  = 0;
    int         failed = 0;
    logic [2:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input bit lo, input logic [7:0] m);
        if (lo) begin
            bus_lo.d0 = m[0]; bus_lo.d1 = m[1]; bus_lo.d2 = m[2]; bus_lo.d3 = m[3];
            bus_lo.d4 = m[4]; bus_lo.d5 = m[5]; bus_lo.d6 = m[6]; bus_lo.d7 = m[7];
        end else begin
            bus_hi.d0 = m[0]; bus_hi.d1 = m[1]; bus_hi.d2 = m[2]; bus_hi.d3 = m[3];
            bus_hi.d4 = m[4]; bus_hi.d5 = m[5]; bus_hi.d6 = m[6]; bus_hi.d7 = m[7];
        end
    endtask

    task automatic set_ack(input bit lo, input logic v);
        if (lo) bus_lo.ack = v;
        else    bus_hi.ack = v;
    endtask

    function automatic logic valid_of(input bit lo);
        return lo ? bus_lo.valid : bus_hi.valid;
    endfunction

    function automatic logic [2:0] code_of(input bit lo);
        return lo ? {bus_lo.x, bus_lo.y, bus_lo.z} : {bus_hi.x, bus_hi.y, bus_hi.z};
    endfunction

    function automatic logic [7:0] pend_of(input bit lo);
        return lo ? bus_lo.pending : bus_hi.pending;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for valid, then pops the expected code and compares.
    task automatic wait_grant(input bit lo, input string tag, output int waits);
        waits = 0;
        while (valid_of(lo) !== 1'b1 && waits < 12) begin
            step();
            waits++;
        end
        check({tag, "_valid"}, {7'd0, valid_of(lo)}, 8'h01);
        tests++;
        assert (exp_q.size() != 0) else begin
            failed++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) check({tag, "_code"}, {5'd0, code_of(lo)}, {5'd0, exp_q.pop_front()});
    endtask

    task automatic do_ack(input bit lo, input string tag);
        set_ack(lo, 1'b1);
        step();
        set_ack(lo, 1'b0);
        check({tag, "_ack_valid"}, {7'd0, valid_of(lo)}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        // Reset held with all requests high
        rst_n = 1'b0;
        set_d(1'b0, 8'hFF); set_d(1'b1, 8'hFF);
        set_ack(1'b0, 1'b0); set_ack(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_valid", {7'd0, valid_of(1'b0)}, 8'h00);
            check("rst_code", {5'd0, code_of(1'b0)}, 8'h00);
            check("rst_pending", pend_of(1'b0), 8'h00);
            check("rst_pending_lo", pend_of(1'b1), 8'h00);
        end
        set_d(1'b0, 8'h00); set_d(1'b1, 8'h00);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check("rel_valid", {7'd0, valid_of(1'b0)}, 8'h00);
            check("rel_code", {5'd0, code_of(1'b0)}, 8'h00);
            check("rel_pending", pend_of(1'b0), 8'h00);
        end

        // Full code sweep
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(3'(i));
            set_d(1'b0, 8'd1 << i);
            step();
            set_d(1'b0, 8'h00);
            check("sweep_early_valid", {7'd0, valid_of(1'b0)}, 8'h00);
            check("sweep_pending", pend_of(1'b0), 8'd1 << i);
            wait_grant(1'b0, "sweep", w);
            check("sweep_latency", 8'(w), 8'd1);
            do_ack(1'b0, "sweep");
            check("sweep_cleared", pend_of(1'b0), 8'h00);
        end

        // Priority, d7 highest
        exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd2);
        set_d(1'b0, 8'hA4);
        step();
        set_d(1'b0, 8'h00);
        check("prio_hi_pend0", pend_of(1'b0), 8'hA4);
        wait_grant(1'b0, "prio_hi_g0", w);
        do_ack(1'b0, "prio_hi_g0");
        check("prio_hi_pend1", pend_of(1'b0), 8'h24);
        wait_grant(1'b0, "prio_hi_g1", w);
        check("prio_hi_gap1", 8'(w), 8'd1);
        do_ack(1'b0, "prio_hi_g1");
        check("prio_hi_pend2", pend_of(1'b0), 8'h04);
        wait_grant(1'b0, "prio_hi_g2", w);
        check("prio_hi_gap2", 8'(w), 8'd1);
        do_ack(1'b0, "prio_hi_g2");
        check("prio_hi_pend3", pend_of(1'b0), 8'h00);

        // Priority, d0 highest
        exp_q.push_back(3'd2); exp_q.push_back(3'd5); exp_q.push_back(3'd7);
        set_d(1'b1, 8'hA4);
        step();
        set_d(1'b1, 8'h00);
        check("prio_lo_pend0", pend_of(1'b1), 8'hA4);
        wait_grant(1'b1, "prio_lo_g0", w);
        do_ack(1'b1, "prio_lo_g0");
        check("prio_lo_pend1", pend_of(1'b1), 8'hA0);
        wait_grant(1'b1, "prio_lo_g1", w);
        check("prio_lo_gap1", 8'(w), 8'd1);
        do_ack(1'b1, "prio_lo_g1");
        check("prio_lo_pend2", pend_of(1'b1), 8'h80);
        wait_grant(1'b1, "prio_lo_g2", w);
        do_ack(1'b1, "prio_lo_g2");
        check("prio_lo_pend3", pend_of(1'b1), 8'h00);

        // Code freeze while a higher-priority request arrives
        exp_q.push_back(3'd1);
        set_d(1'b0, 8'h02);
        step();
        set_d(1'b0, 8'h00);
        wait_grant(1'b0, "freeze_g0", w);
        set_d(1'b0, 8'h40);
        step();
        set_d(1'b0, 8'h00);
        for (int c = 0; c < 2; c++) begin
            check("freeze_code", {5'd0, code_of(1'b0)}, 8'h01);
            check("freeze_valid", {7'd0, valid_of(1'b0)}, 8'h01);
            check("freeze_pending", pend_of(1'b0), 8'h42);
            step();
        end
        exp_q.push_back(3'd6);
        do_ack(1'b0, "freeze_g0");
        check("freeze_pend_after", pend_of(1'b0), 8'h40);
        wait_grant(1'b0, "freeze_g1", w);
        check("freeze_gap", 8'(w), 8'd1);
        do_ack(1'b0, "freeze_g1");
        check("freeze_cleared", pend_of(1'b0), 8'h00);

        // Set and clear on the same edge
        exp_q.push_back(3'd3);
        set_d(1'b0, 8'h08);
        step();
        set_d(1'b0, 8'h00);
        wait_grant(1'b0, "setclr_g0", w);
        set_d(1'b0, 8'h08);
        set_ack(1'b0, 1'b1);
        step();
        set_d(1'b0, 8'h00);
        set_ack(1'b0, 1'b0);
        check("setclr_valid", {7'd0, valid_of(1'b0)}, 8'h00);
        check("setclr_pending", pend_of(1'b0), 8'h08);
        exp_q.push_back(3'd3);
        wait_grant(1'b0, "setclr_g1", w);
        check("setclr_gap", 8'(w), 8'd1);
        do_ack(1'b0, "setclr_g1");
        check("setclr_cleared", pend_of(1'b0), 8'h00);

        // Asynchronous reset during a grant discards it
        exp_q.push_back(3'd4);
        set_d(1'b0, 8'h11);
        step();
        set_d(1'b0, 8'h00);
        wait_grant(1'b0, "arst_g0", w);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {7'd0, valid_of(1'b0)}, 8'h00);
        check("arst_pending", pend_of(1'b0), 8'h00);
        check("arst_code", {5'd0, code_of(1'b0)}, 8'h00);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("arst_post_valid", {7'd0, valid_of(1'b0)}, 8'h00);
            check("arst_post_pending", pend_of(1'b0), 8'h00);
        end
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
